hamming_secded_tx: RTL and testbench

- Transmit-side counterpart of the channel decoder.
- Accepts 8-bit bytes over a valid/ready handshake and encodes each into a 13-bit SEC-DED codeword: Hamming(12,8) plus overall parity.
- Serialises each codeword onto a single line with start/stop framing.
- An optional per-frame error-injection mask lets benches exercise the receiver's detect/correct paths without hierarchical forcing.

---
 rtl/hamming_secded_tx.sv | 165 ++++++++++++++++
 tb/tb_hamming_secded_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_tx.sv
// hamming_secded_tx
// -----------------------------------------------------------------------------
// Transmit side of the SEC-DED serial link. Each byte accepted over the
// valid/ready handshake is encoded into a 13-bit codeword (Hamming(12,8)
// plus an overall parity bit). The codeword is XORed with a per-frame
// injection mask and then shifted out LSB first. Each frame is one start
// bit, thirteen data bits and one stop bit.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      byte to send
//   in_inject    XOR mask applied to the codeword (bit i flips codeword bit i)
//   in_valid     in_data / in_inject valid
//   in_ready     block can accept a byte this cycle (IDLE only)
//   tx_serial    registered serial line
//   tx_busy      frame in progress (START, DATA, STOP)
//   tx_codeword  codeword of the current / last frame, after injection
//   frame_done   one-cycle pulse in the first IDLE cycle after STOP
// -----------------------------------------------------------------------------
module hamming_secded_tx #(
   parameter int   CLKS_PER_BIT = 4,
   parameter logic IDLE_LEVEL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic [12:0] in_inject,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        tx_serial,
   output logic        tx_busy,
   output logic [12:0] tx_codeword,
   output logic        frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // Codeword bit i carries Hamming position i (1..12). Bit 0 carries the
   // overall parity, so that the complete word has even parity.
   function automatic logic [12:0] secded_encode(input logic [7:0] d);
      logic [12:0] w;
      w      = 13'd0;
      w[3]   = d[0];
      w[5]   = d[1];
      w[6]   = d[2];
      w[7]   = d[3];
      w[9]   = d[4];
      w[10]  = d[5];
      w[11]  = d[6];
      w[12]  = d[7];
      w[1]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      w[2]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      w[4]   = d[1] ^ d[2] ^ d[3] ^ d[7];
      w[8]   = d[4] ^ d[5] ^ d[6] ^ d[7];
      w[0]   = ^w[12:1];
      return w;
   endfunction

   state_t            state_r;
   logic [CNT_W-1:0]  clk_cnt_r;
   logic [3:0]        bit_cnt_r;
   logic [12:0]       shift_r;
   logic [12:0]       enc_word_s;
   logic              bit_end_s;
   logic              accept_s;

   assign enc_word_s = secded_encode(in_data) ^ in_inject;
   assign bit_end_s  = (clk_cnt_r == CNT_LAST);
   assign accept_s   = in_valid & in_ready;

   // Framing FSM: all outputs are registered. The line level for the next
   // bit is loaded on the same edge that enters that bit's state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         clk_cnt_r   <= '0;
         bit_cnt_r   <= 4'd0;
         shift_r     <= 13'd0;
         tx_serial   <= IDLE_LEVEL;
         in_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_codeword <= 13'd0;
         frame_done  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               frame_done <= 1'b0;
               clk_cnt_r  <= '0;
               if (accept_s) begin
                  tx_codeword <= enc_word_s;
                  shift_r     <= enc_word_s;
                  tx_serial   <= ~IDLE_LEVEL;
                  in_ready    <= 1'b0;
                  tx_busy     <= 1'b1;
                  state_r     <= ST_START;
               end else begin
                  tx_serial <= IDLE_LEVEL;
               end
            end

            ST_START: begin
               if (bit_end_s) begin
                  clk_cnt_r <= '0;
                  bit_cnt_r <= 4'd0;
                  tx_serial <= shift_r[0];
                  state_r   <= ST_DATA;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end_s) begin
                  clk_cnt_r <= '0;
                  if (bit_cnt_r == 4'd12) begin
                     tx_serial <= IDLE_LEVEL;
                     state_r   <= ST_STOP;
                  end else begin
                     // Shift the next bit down, and drive it from the old bit 1.
                     shift_r   <= {1'b0, shift_r[12:1]};
                     tx_serial <= shift_r[1];
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (bit_end_s) begin
                  clk_cnt_r  <= '0;
                  bit_cnt_r  <= 4'd0;
                  tx_serial  <= IDLE_LEVEL;
                  in_ready   <= 1'b1;
                  tx_busy    <= 1'b0;
                  frame_done <= 1'b1;
                  state_r    <= ST_IDLE;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            default: begin
               state_r    <= ST_IDLE;
               clk_cnt_r  <= '0;
               bit_cnt_r  <= 4'd0;
               tx_serial  <= IDLE_LEVEL;
               in_ready   <= 1'b1;
               tx_busy    <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_secded_tx.sv
// Testbench for hamming_secded_tx. Two instances run on the same clock, one
// with CLKS_PER_BIT=4 and one with CLKS_PER_BIT=1. Stimulus pushes the
// expected codeword of each accepted byte into a per-instance queue. A
// monitor watches each serial line, rebuilds the frame cycle by cycle and
// checks it against the entry it pops from that queue.
module tb_hamming_secded_tx;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data     [2];
   logic [12:0] in_inject   [2];
   logic        in_valid    [2];
   logic        in_ready    [2];
   logic        tx_serial   [2];
   logic        tx_busy     [2];
   logic [12:0] tx_codeword [2];
   logic        frame_done  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      hamming_secded_tx #(
         .CLKS_PER_BIT (g == 0 ? 4 : 1),
         .IDLE_LEVEL   (1'b1)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_data     (in_data[g]),
         .in_inject   (in_inject[g]),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .tx_serial   (tx_serial[g]),
         .tx_busy     (tx_busy[g]),
         .tx_codeword (tx_codeword[g]),
         .frame_done  (frame_done[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Each entry is {back_to_back_flag, expected codeword}.
   logic [13:0] q0 [$];
   logic [13:0] q1 [$];

   bit          active    [2];
   int          fc        [2];
   int          ferr      [2];
   int          last_done [2];
   logic [12:0] cur_w     [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference encoder built from the generic Hamming rule: the parity bit at
   // position 2^k covers every position whose index has bit k set.
   function automatic logic [12:0] model(input logic [7:0] d);
      int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
      logic [12:0] w;
      logic        p;
      w = 13'd0;
      for (int j = 0; j < 8; j++) w[dpos[j]] = d[j];
      for (int k = 0; k < 4; k++) begin
         p = 1'b0;
         for (int pos = 1; pos <= 12; pos++)
            if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ w[pos];
         w[1 << k] = p;
      end
      w[0] = ($countones(w[12:1]) % 2) == 1;
      return w;
   endfunction

   function automatic int cpb_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic q_push(input int i, input logic [13:0] e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   function automatic int q_size(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [13:0] q_pop(input int i);
      return (i == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   // Offer one byte and wait (bounded) for the transfer. With keep=1,
   // in_valid stays high after the accept so the next call presents the
   // following byte while the frame is in flight.
   task automatic send(input int i, input logic [7:0] d, input logic [12:0] inj,
                       input logic [12:0] expw, input bit b2b, input bit keep);
      int n;
      @(negedge clk);
      in_data[i]   = d;
      in_inject[i] = inj;
      in_valid[i]  = 1'b1;
      n = 0;
      while (!in_ready[i] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[i]) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid[i] = 1'b0;
      end else begin
         q_push(i, {b2b, expw});
         @(posedge clk);
         #1;
         if (!keep) in_valid[i] = 1'b0;
      end
   endtask

   task automatic run_seq(input int i);
      logic [7:0]  d;
      logic [12:0] inj;
      bit          keep;
      bit          prev_keep;
      send(i, 8'hAA, 13'h0000, 13'h14B1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      send(i, 8'hFF, 13'h0000, 13'h1EEE, 1'b0, 1'b1);
      send(i, 8'h00, 13'h0000, 13'h0000, 1'b1, 1'b0);
      send(i, 8'hAA, 13'h0001, 13'h14B0, 1'b0, 1'b0);
      send(i, 8'hAA, 13'h0006, 13'h14B7, 1'b0, 1'b0);
      prev_keep = 1'b0;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         inj  = ($urandom_range(0, 3) == 0) ? 13'(1 << $urandom_range(0, 12)) : 13'd0;
         keep = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
         send(i, d, inj, model(d) ^ inj, prev_keep, keep);
         prev_keep = keep;
         if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
   endtask

   // One monitor step per instance per falling edge.
   task automatic mon_step(input int i);
      int          p;
      int          idx;
      logic        el;
      logic [12:0] w;
      logic [13:0] e;
      p = cpb_of(i);
      if (!rst_n) begin
         active[i] = 1'b0;
         chk("reset_outputs", {tx_serial[i], tx_busy[i], frame_done[i], in_ready[i]}, 4'b1001);
         return;
      end
      if (!active[i]) begin
         if (tx_serial[i] == 1'b0) begin
            if (q_size(i) == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
               e        = q_pop(i);
               cur_w[i] = e[12:0];
               chk("codeword", tx_codeword[i], e[12:0]);
               if (e[13]) chk("b2b_gap", cyc - last_done[i], 1);
               active[i] = 1'b1;
               fc[i]     = 0;
               ferr[i]   = 0;
            end
         end else begin
            chk("idle_outputs", {tx_busy[i], frame_done[i], in_ready[i]}, 3'b001);
         end
      end
      if (active[i]) begin
         if (fc[i] < 15 * p) begin
            w = cur_w[i];
            if (fc[i] < p) el = 1'b0;
            else if (fc[i] < 14 * p) begin
               idx = fc[i] / p - 1;
               el  = w[idx];
            end else el = 1'b1;
            if ({tx_serial[i], tx_busy[i], frame_done[i], in_ready[i], tx_codeword[i]} !==
                {el, 1'b1, 1'b0, 1'b0, w}) begin
               ferr[i]++;
            end
            fc[i]++;
         end else begin
            chk("frame_bad_cycles", ferr[i], 0);
            chk("frame_end", {tx_serial[i], tx_busy[i], frame_done[i], in_ready[i]}, 4'b1011);
            active[i]    = 1'b0;
            last_done[i] = cyc;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         active[i]    = 1'b0;
         fc[i]        = 0;
         ferr[i]      = 0;
         last_done[i] = -100;
         cur_w[i]     = 13'd0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) mon_step(i);
      end
   end

   initial begin
      int n;
      logic [7:0] d;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data[i]   = 8'd0;
         in_inject[i] = 13'd0;
         in_valid[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);

      fork
         run_seq(0);
         run_seq(1);
      join

      // Abandon a frame on the slow instance about 30 cycles in.
      n = 0;
      while ((active[0] || q_size(0) != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      d = 8'($urandom);
      send(0, d, 13'd0, model(d), 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      chk("busy_before_reset", tx_busy[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_async_serial", tx_serial[0], 1'b1);
      chk("reset_async_busy", tx_busy[0], 1'b0);
      chk("reset_async_done", frame_done[0], 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send(0, 8'hAA, 13'h0000, 13'h14B1, 1'b0, 1'b0);
      send(1, 8'h5C, 13'h0000, model(8'h5C), 1'b0, 1'b0);

      n = 0;
      while ((active[0] || active[1] || q_size(0) != 0 || q_size(1) != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
